// File: rtl/ysyx_l1i_cache.sv
// ysyx_l1i_cache: direct-mapped L1 instruction cache for the IFU.
// Hits return the word in the same cycle; a miss refills the whole line with one read burst.
// Optional hit/miss counters (perf_hit, perf_miss) are built when YSYX_L1I_PERF_EN is defined.
`ifndef YSYX_XLEN
`define YSYX_XLEN 32
`endif
`ifndef YSYX_L1I_LEN
`define YSYX_L1I_LEN 4
`endif
`ifndef YSYX_L1I_LINE_LEN
`define YSYX_L1I_LINE_LEN 2
`endif

module ysyx_l1i_cache #(
  parameter int unsigned XLEN         = `YSYX_XLEN,
  parameter int unsigned L1I_LEN      = `YSYX_L1I_LEN,
  parameter int unsigned L1I_LINE_LEN = `YSYX_L1I_LINE_LEN
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [XLEN-1:0] ifu_pc,
  input  logic            ifu_invalid,
  output logic [31:0]     ifu_inst,
  output logic            ifu_valid,
  output logic            bus_arvalid,
  output logic [XLEN-1:0] bus_araddr,
  input  logic            bus_rready,
  input  logic [XLEN-1:0] bus_rdata,
  input  logic            bus_rvalid,
  input  logic            bus_rlast
`ifdef YSYX_L1I_PERF_EN
  ,
  output logic [31:0]     perf_hit,
  output logic [31:0]     perf_miss
`endif
);

  localparam int unsigned LINES = 1 << L1I_LEN;
  localparam int unsigned WORDS = 1 << L1I_LINE_LEN;
  localparam int unsigned OFF_W = L1I_LINE_LEN + 2;
  localparam int unsigned TAG_W = XLEN - L1I_LEN - OFF_W;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    FILL = 2'd2
  } state_t;

  state_t                  state;
  logic [XLEN-1:0]         data_q [LINES][WORDS];
  logic [TAG_W-1:0]        tag_q  [LINES];
  logic [LINES-1:0]        vld_q;
  logic [L1I_LINE_LEN-1:0] cnt;
  logic                    poison;

  logic [TAG_W-1:0]        pc_tag;
  logic [L1I_LEN-1:0]      pc_idx;
  logic [L1I_LINE_LEN-1:0] pc_woff;
  logic [TAG_W-1:0]        fill_tag;
  logic [L1I_LEN-1:0]      fill_idx;
  logic                    hit;
  logic                    fill_beat;
  logic                    fill_done;
  logic                    unused_pc_bits;

  // Address split of the fetch pc and of the latched refill line address
  assign pc_tag         = ifu_pc[XLEN-1 -: TAG_W];
  assign pc_idx         = ifu_pc[OFF_W +: L1I_LEN];
  assign pc_woff        = ifu_pc[2 +: L1I_LINE_LEN];
  assign fill_tag       = bus_araddr[XLEN-1 -: TAG_W];
  assign fill_idx       = bus_araddr[OFF_W +: L1I_LEN];
  assign unused_pc_bits = ^ifu_pc[1:0];

  // Lookups only hit while idle, so a line being refilled is never read early
  assign hit       = vld_q[pc_idx] && (tag_q[pc_idx] == pc_tag) && (state == IDLE);
  assign ifu_valid = hit;
  assign ifu_inst  = data_q[pc_idx][pc_woff][31:0];

  assign fill_beat = (state == FILL) && bus_rvalid;
  assign fill_done = fill_beat && bus_rlast;

  // Line storage: beats land at the running beat counter, tag written on the last beat
  always_ff @(posedge clock) begin
    if (fill_beat) begin
      data_q[fill_idx][cnt] <= bus_rdata;
    end
    if (fill_done) begin
      tag_q[fill_idx] <= fill_tag;
    end
  end

  // Refill FSM with valid bits and flush/poison handling
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      bus_arvalid <= 1'b0;
      bus_araddr  <= '0;
      cnt         <= '0;
      poison      <= 1'b0;
      vld_q       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (!hit) begin
            state       <= REQ;
            bus_arvalid <= 1'b1;
            bus_araddr  <= {ifu_pc[XLEN-1:OFF_W], OFF_W'(0)};
          end
        end
        REQ: begin
          if (bus_rready) begin
            state       <= FILL;
            bus_arvalid <= 1'b0;
            cnt         <= '0;
          end
        end
        FILL: begin
          if (bus_rvalid) begin
            cnt <= cnt + L1I_LINE_LEN'(1);
            if (bus_rlast) begin
              state  <= IDLE;
              poison <= 1'b0;
              if (!poison) begin
                vld_q[fill_idx] <= 1'b1;
              end
            end
          end
        end
        default: state <= IDLE;
      endcase
      // Flush wins over the valid set at rlast; a flush on the last beat needs no poison
      if (ifu_invalid) begin
        vld_q <= '0;
        if ((state != IDLE) && !fill_done) begin
          poison <= 1'b1;
        end
      end
    end
  end

`ifdef YSYX_L1I_PERF_EN
  // Hit cycles and miss starts, free-running and wrapping
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      perf_hit  <= '0;
      perf_miss <= '0;
    end else begin
      if (hit) begin
        perf_hit <= perf_hit + 32'd1;
      end
      if ((state == IDLE) && !hit) begin
        perf_miss <= perf_miss + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_ysyx_l1i_cache.sv
// tb_ysyx_l1i_cache: lookup table plus hand-written refill, flush, stall and reset sequences.
`timescale 1ns/1ps
module tb_ysyx_l1i_cache;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] ifu_pc;
  logic        ifu_invalid;
  logic [31:0] ifu_inst;
  logic        ifu_valid;
  logic        bus_arvalid;
  logic [31:0] bus_araddr;
  logic        bus_rready;
  logic [31:0] bus_rdata;
  logic        bus_rvalid;
  logic        bus_rlast;
`ifdef YSYX_L1I_PERF_EN
  logic [31:0] perf_hit;
  logic [31:0] perf_miss;
`endif

  ysyx_l1i_cache dut (
    .clock       (clock),
    .reset       (reset),
    .ifu_pc      (ifu_pc),
    .ifu_invalid (ifu_invalid),
    .ifu_inst    (ifu_inst),
    .ifu_valid   (ifu_valid),
    .bus_arvalid (bus_arvalid),
    .bus_araddr  (bus_araddr),
    .bus_rready  (bus_rready),
    .bus_rdata   (bus_rdata),
    .bus_rvalid  (bus_rvalid),
    .bus_rlast   (bus_rlast)
`ifdef YSYX_L1I_PERF_EN
    ,
    .perf_hit    (perf_hit),
    .perf_miss   (perf_miss)
`endif
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] pc;
    bit          miss;
    logic [31:0] inst;
  } vec_t;

  vec_t        vecs [10];
  int          vectors = 0;
  int          miscompares = 0;
  logic [31:0] inst_q [$];
  logic [31:0] ar_q [$];

  // Backing memory: line 0x8000_0000 holds 0x11..0x44, everything else is addr ^ 0xDEAD_0000
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    logic [31:0] w;
    w = {a[31:2], 2'b00};
    if (w[31:4] == 28'h8000000) return 32'h11 * (32'(w[3:2]) + 32'd1);
    return w ^ 32'hDEAD_0000;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Bus side of one refill: called just after the edge that leaves IDLE
  task automatic serve(input int stall, input int inv_beat);
    logic [31:0] exp;
    int n;
    n = 0;
    exp = 32'hFFFF_FFFF;
    if (ar_q.size() != 0) exp = ar_q.pop_front();
    @(negedge clock);
    while (!bus_arvalid && n < 20) begin
      @(negedge clock);
      n++;
    end
    check("arvalid", 32'(bus_arvalid), 32'd1);
    check("araddr", bus_araddr, exp);
    for (int s = 0; s < stall; s++) begin
      @(posedge clock); #1;
      @(negedge clock);
      check("stall_arvalid", 32'(bus_arvalid), 32'd1);
      check("stall_araddr", bus_araddr, exp);
    end
    bus_rready = 1'b1;
    tick();
    bus_rready = 1'b0;
    for (int b = 0; b < 4; b++) begin
      bus_rvalid  = 1'b1;
      bus_rdata   = mem_word(exp + 32'(4 * b));
      bus_rlast   = (b == 3);
      ifu_invalid = (b == inv_beat);
      @(negedge clock);
      check("fill_arvalid", 32'(bus_arvalid), 32'd0);
      check("fill_valid", 32'(ifu_valid), 32'd0);
      tick();
    end
    bus_rvalid  = 1'b0;
    bus_rlast   = 1'b0;
    ifu_invalid = 1'b0;
  endtask

  // One fetch: a hit is checked immediately, a miss is refilled and then checked
  task automatic lookup(input logic [31:0] pc, input bit miss, input logic [31:0] exp_inst,
                        input int stall);
    int c0;
    ifu_pc = pc;
    inst_q.push_back(exp_inst);
    @(negedge clock);
    check(miss ? "miss_valid" : "hit_valid", 32'(ifu_valid), miss ? 32'd0 : 32'd1);
    if (miss) begin
      c0 = cyc;
      ar_q.push_back(pc & 32'hFFFF_FFF0);
      tick();
      serve(stall, -1);
      @(negedge clock);
      check("latency", 32'(cyc - c0), 32'(6 + stall));
      check("refill_valid", 32'(ifu_valid), 32'd1);
    end else begin
      check("hit_arvalid", 32'(bus_arvalid), 32'd0);
    end
    check("inst", ifu_inst, inst_q.pop_front());
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    ifu_pc      = 32'h8000_0004;
    ifu_invalid = 1'b0;
    bus_rready  = 1'b0;
    bus_rdata   = 32'h0;
    bus_rvalid  = 1'b0;
    bus_rlast   = 1'b0;

    vecs[0] = '{32'h8000_0004, 1'b1, 32'h0000_0022};
    vecs[1] = '{32'h8000_0000, 1'b0, 32'h0000_0011};
    vecs[2] = '{32'h8000_0008, 1'b0, 32'h0000_0033};
    vecs[3] = '{32'h8000_000C, 1'b0, 32'h0000_0044};
    vecs[4] = '{32'h8000_0100, 1'b1, 32'h5EAD_0100};
    vecs[5] = '{32'h8000_0000, 1'b1, 32'h0000_0011};
    vecs[6] = '{32'h8000_0010, 1'b1, 32'h5EAD_0010};
    vecs[7] = '{32'h8000_0014, 1'b0, 32'h5EAD_0014};
    vecs[8] = '{32'h8000_0004, 1'b0, 32'h0000_0022};
    vecs[9] = '{32'h8000_0106, 1'b1, 32'h5EAD_0104};

    #2 reset = 1'b1;
    repeat (2) @(posedge clock);
    @(negedge clock);
    check("rst_arvalid", 32'(bus_arvalid), 32'd0);
    check("rst_araddr", bus_araddr, 32'd0);
    check("rst_valid", 32'(ifu_valid), 32'd0);
`ifdef YSYX_L1I_PERF_EN
    check("rst_perf_miss", perf_miss, 32'd0);
`endif
    tick();
    reset = 1'b0;

    // Table: cold miss, same-line hits, conflict, second index, pc[1:0] ignored
    for (int i = 0; i < 10; i++) begin
      lookup(vecs[i].pc, vecs[i].miss, vecs[i].inst, 0);
`ifdef YSYX_L1I_PERF_EN
      if (i == 5) check("perf_miss_conflict", perf_miss, 32'd3);
`endif
    end

    // fence.i on beat 2: line written but left invalid, same line requested again
    ifu_pc = 32'h8000_0020;
    @(negedge clock);
    check("poison_miss", 32'(ifu_valid), 32'd0);
    ar_q.push_back(32'h8000_0020);
    tick();
    serve(0, 1);
    @(negedge clock);
    check("poison_valid", 32'(ifu_valid), 32'd0);
    check("poison_idle_arvalid", 32'(bus_arvalid), 32'd0);
    ar_q.push_back(32'h8000_0020);
    inst_q.push_back(32'h5EAD_0020);
    tick();
    serve(0, -1);
    @(negedge clock);
    check("repoll_valid", 32'(ifu_valid), 32'd1);
    check("repoll_inst", ifu_inst, inst_q.pop_front());
    tick();

    // Flush also dropped line 0; refill it with a stalled address phase
    lookup(32'h8000_0000, 1'b1, 32'h0000_0011, 5);
    lookup(32'h8000_0020, 1'b0, 32'h5EAD_0020, 0);
    lookup(32'h8000_0000, 1'b0, 32'h0000_0011, 0);

    // Flush while idle: both cached lines miss afterwards
    ifu_pc = 32'h8000_0020;
    ifu_invalid = 1'b1;
    tick();
    ifu_invalid = 1'b0;
    lookup(32'h8000_0020, 1'b1, 32'h5EAD_0020, 0);
    lookup(32'h8000_0000, 1'b1, 32'h0000_0011, 0);

    // pc moves during REQ: original burst completes, new pc looked up afterwards
    ifu_pc = 32'h8000_0040;
    @(negedge clock);
    check("move_miss", 32'(ifu_valid), 32'd0);
    ar_q.push_back(32'h8000_0040);
    inst_q.push_back(32'h5EAD_0044);
    tick();
    ifu_pc = 32'h8000_0044;
    serve(2, -1);
    @(negedge clock);
    check("move_valid", 32'(ifu_valid), 32'd1);
    check("move_inst", ifu_inst, inst_q.pop_front());
    tick();

    // Reset mid-burst with stray beats around it
    ifu_pc = 32'h8000_0080;
    @(negedge clock);
    check("rstb_miss", 32'(ifu_valid), 32'd0);
    tick();
    bus_rready = 1'b1;
    tick();
    bus_rready = 1'b0;
    bus_rvalid = 1'b1;
    bus_rdata  = 32'hBAD0_0000;
    tick();
    reset     = 1'b1;
    bus_rlast = 1'b1;
    @(negedge clock);
    check("rstb_arvalid", 32'(bus_arvalid), 32'd0);
    check("rstb_araddr", bus_araddr, 32'd0);
    check("rstb_valid", 32'(ifu_valid), 32'd0);
`ifdef YSYX_L1I_PERF_EN
    check("rstb_perf_miss", perf_miss, 32'd0);
`endif
    tick();
    reset = 1'b0;
    @(negedge clock);
    check("stray_valid", 32'(ifu_valid), 32'd0);
    ar_q.push_back(32'h8000_0080);
    inst_q.push_back(32'h5EAD_0080);
    tick();
    bus_rvalid = 1'b0;
    bus_rlast  = 1'b0;
    serve(0, -1);
    @(negedge clock);
    check("rstb_refill_valid", 32'(ifu_valid), 32'd1);
    check("rstb_refill_inst", ifu_inst, inst_q.pop_front());
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
